ttl_prio_encoder: RTL and testbench

Registered 8-to-3 priority encoder with request capture and valid/acknowledge handshake; the inverse of the octal decoder. It sits on the CPU's interrupt/select side. It collects one-hot or multi-hot request lines, presents the highest-numbered pending request as a 3-bit code, and holds that code until the consumer acknowledges it. The acknowledged bit is then retired.

---
 rtl/ttl_pkg.sv | 23 ++
 rtl/ttl_prio8.sv | 15 +
 rtl/ttl_prio_encoder.sv | 113 +++++++++++
 tb/tb_ttl_prio_encoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared constants, FSM state type and priority helper for the
// registered 8-to-3 priority encoder.
package ttl_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Highest set index of v; 0 when v is all zero.
    function automatic logic [W-1:0] prio8(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ttl_prio8.sv
// Combinational 8-to-3 priority core (74148 equivalent, active-high).
// Ports: In[7:0] request vector, En enable, Out[2:0] highest index, Gs group-select (En & |In).
module ttl_prio8
    import ttl_pkg::*;
(
    input  logic [N-1:0] In,
    input  logic         En,
    output logic [W-1:0] Out,
    output logic         Gs
);

    assign Gs  = En & (|In);
    assign Out = Gs ? prio8(In) : '0;

endmodule

// File: rtl/ttl_prio_encoder.sv
// Registered 8-to-3 priority encoder: captures requests into Pend, presents the highest
// pending index on Code with Valid, and retires that bit on Ack.
// Ports: Clk, Reset_n (async, active-low), Req[7:0], En, Ack; Code[2:0], Valid, Any, Pend[7:0], Lost.
// Macro TTL_PRIO_ENC_EDGE_EN: rising-edge capture with Lost; otherwise level capture, Lost=0.
// Outputs are modelled with zero delay; Any is the only combinational output (OR of Pend).
module ttl_prio_encoder
    import ttl_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] Req,
    input  logic         En,
    input  logic         Ack,
    output logic [W-1:0] Code,
    output logic         Valid,
    output logic         Any,
    output logic [N-1:0] Pend,
    output logic         Lost
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pend;
    logic [W-1:0]   r_code;
    logic [W-1:0]   w_code_nxt;
    logic           r_valid;
    logic           w_valid_nxt;
    logic           r_lost;
    logic           w_lost;
    logic           w_retire;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_set;
    logic [W-1:0]   w_prio;
    logic           w_gs;

    ttl_prio8 u_prio8 (
        .In  (r_pend),
        .En  (En),
        .Out (w_prio),
        .Gs  (w_gs)
    );

    assign w_retire = (r_state == BUSY) & Ack;
    assign w_clr    = w_retire ? (N'(1) << r_code) : '0;

`ifdef TTL_PRIO_ENC_EDGE_EN
    logic [N-1:0] r_req_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_req_q <= '0;
        else          r_req_q <= Req;
    end

    assign w_set  = Req & ~r_req_q;
    // A rise on a bit that stays pending is merged and reported.
    assign w_lost = |(w_set & r_pend & ~w_clr);
`else
    assign w_set  = Req;
    assign w_lost = 1'b0;
`endif

    // Set after clear: a new request on the retiring bit keeps it pending.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend <= '0;
            r_lost <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_lost <= w_lost;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Code is latched only on IDLE->BUSY so it stays frozen while BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        unique case (r_state)
            IDLE: begin
                if (w_gs) begin
                    w_state_nxt = BUSY;
                    w_code_nxt  = w_prio;
                    w_valid_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (Ack) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
        endcase
    end

    assign Code  = r_code;
    assign Valid = r_valid;
    assign Pend  = r_pend;
    assign Any   = |r_pend;
    assign Lost  = r_lost;

endmodule

// File: tb/tb_ttl_prio_encoder.sv
// Scoreboard bench for ttl_prio_encoder: a per-edge reference model queues the
// expected outputs, a negedge monitor pops and compares them.
module tb_ttl_prio_encoder;

`ifdef TTL_PRIO_ENC_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] Req;
    logic       En;
    logic       Ack;
    logic [2:0] Code;
    logic       Valid;
    logic       Any;
    logic [7:0] Pend;
    logic       Lost;

    ttl_prio_encoder dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Req     (Req),
        .En      (En),
        .Ack     (Ack),
        .Code    (Code),
        .Valid   (Valid),
        .Any     (Any),
        .Pend    (Pend),
        .Lost    (Lost)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] pend;
        logic       valid;
        logic [2:0] code;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Reference model: pending set, busy flag and presented code.
    logic [7:0] m_pend, m_prev, m_rise, m_nxt;
    logic       m_busy, m_retire, m_lost;
    logic [2:0] m_code;
    int         m_hi;

    initial forever begin
        @(posedge Clk or negedge Reset_n);
        if (!Reset_n) begin
            m_pend = '0;
            m_prev = '0;
            m_busy = 1'b0;
            m_code = '0;
            exp_q.delete();
        end else begin
            m_retire = m_busy && Ack;
            m_lost   = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_rise[i] = EDGE ? (Req[i] && !m_prev[i]) : Req[i];
                if (m_rise[i])
                    m_nxt[i] = 1'b1;
                else if (m_retire && m_code == 3'(i))
                    m_nxt[i] = 1'b0;
                else
                    m_nxt[i] = m_pend[i];
                if (EDGE && m_rise[i] && m_pend[i] &&
                    !(m_retire && m_code == 3'(i)))
                    m_lost = 1'b1;
            end
            if (m_busy) begin
                if (Ack) m_busy = 1'b0;
            end else if (En && m_pend != 0) begin
                m_hi = -1;
                for (int i = 0; i < 8; i++)
                    if (m_pend[i]) m_hi = i;
                m_code = 3'(m_hi);
                m_busy = 1'b1;
            end
            m_pend = m_nxt;
            m_prev = Req;
            exp_q.push_back('{pend: m_pend, valid: m_busy,
                              code: m_code, lost: m_lost});
        end
    end

    // Monitor
    exp_t e;
    initial forever begin
        @(negedge Clk);
        if (!Reset_n) begin
            chk("rst_pend",  32'(Pend),  0);
            chk("rst_valid", 32'(Valid), 0);
            chk("rst_code",  32'(Code),  0);
            chk("rst_any",   32'(Any),   0);
            chk("rst_lost",  32'(Lost),  0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pend",  32'(Pend),  32'(e.pend));
            chk("sb_valid", 32'(Valid), 32'(e.valid));
            chk("sb_any",   32'(Any),   32'(|e.pend));
            chk("sb_lost",  32'(Lost),  32'(e.lost));
            if (e.valid) chk("sb_code", 32'(Code), 32'(e.code));
        end
    end

    // Apply inputs, then let one edge sample them; returns 3 after that edge.
    task automatic step(input logic [7:0] r, input logic en, input logic ak);
        Req = r;
        En  = en;
        Ack = ak;
        @(posedge Clk);
        #3;
    endtask

    int vcnt;

    initial begin
        Reset_n = 1'b0;
        Req = '0;
        En  = 1'b0;
        Ack = 1'b0;
        repeat (3) @(posedge Clk);
        #3 Reset_n = 1'b1;
        chk("post_rst_valid", 32'(Valid), 0);

        // Priority and freeze
        step(8'h24, 1, 0);
        chk("pend_24", 32'(Pend), 32'h24);
        chk("valid_lat", 32'(Valid), 0);
        step(8'h00, 1, 0);
        chk("code5", 32'(Code), 5);
        chk("valid5", 32'(Valid), 1);
        step(8'h80, 1, 0);
        step(8'h00, 1, 0);
        chk("freeze5", 32'(Code), 5);
        step(8'h00, 1, 1);
        chk("ack_valid0", 32'(Valid), 0);
        chk("ack_pend", 32'(Pend), 32'h84);
        step(8'h00, 1, 0);
        chk("code7", 32'(Code), 7);
        step(8'h00, 1, 1);
        step(8'h00, 1, 0);
        chk("code2", 32'(Code), 2);
        step(8'h00, 1, 1);

        // En gating and Ack boundary
        step(8'h01, 0, 0);
        step(8'h00, 0, 0);
        step(8'h00, 0, 0);
        chk("en0_valid", 32'(Valid), 0);
        chk("en0_any", 32'(Any), 1);
        step(8'h00, 1, 0);
        chk("en1_valid", 32'(Valid), 1);
        chk("en1_code0", 32'(Code), 0);
        step(8'h00, 1, 1);
        chk("ack_clr_pend", 32'(Pend), 0);
        chk("ack_clr_valid", 32'(Valid), 0);
        step(8'h00, 0, 1);
        chk("idle_ack_pend", 32'(Pend), 0);
        chk("idle_ack_valid", 32'(Valid), 0);

        // Reset while BUSY
        step(8'h10, 1, 0);
        step(8'h00, 1, 0);
        chk("code4", 32'(Code), 4);
        Reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(Valid), 0);
        chk("async_code", 32'(Code), 0);
        chk("async_pend", 32'(Pend), 0);
        @(posedge Clk);
        #3 Reset_n = 1'b1;
        step(8'h00, 1, 0);
        step(8'h00, 1, 0);
        chk("after_rst_valid", 32'(Valid), 0);

        // Held-high request
        vcnt = 0;
        repeat (10) begin
            step(8'h08, 1, 1);
            if (Valid) vcnt++;
        end
        if (EDGE) begin
            chk("edge_one_code", 32'(vcnt), 1);
            step(8'h00, 1, 0);
            step(8'h08, 1, 0);
            step(8'h00, 1, 0);
            chk("edge_code3", 32'(Code), 3);
            step(8'h08, 1, 0);
            chk("lost_pulse", 32'(Lost), 1);
            chk("lost_code", 32'(Code), 3);
            step(8'h00, 1, 0);
            chk("lost_end", 32'(Lost), 0);
            step(8'h08, 1, 1);
            chk("same_edge_pend", 32'(Pend[3]), 1);
            chk("same_edge_lost", 32'(Lost), 0);
            step(8'h00, 1, 0);
            step(8'h00, 1, 1);
        end else begin
            chk("level_codes", 32'(vcnt), 5);
            chk("level_lost", 32'(Lost), 0);
            step(8'h00, 1, 1);
        end
        chk("hold_drain", 32'(Pend), 0);

        // Random traffic
        repeat (400) begin
            step(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                 ($urandom_range(0, 3) != 0),
                 1'($urandom));
        end
        repeat (20) step(8'h00, 1, 1);
        chk("final_pend", 32'(Pend), 0);

        @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
